// File: rtl/video_timing_gen_pkg.sv
// Shared video configuration: coordinate widths and the default 720p60 raster.
package configPackage;

    // Coordinate / counter widths used across the HDMI pixel path
    localparam int VIDEO_X_BITWIDTH = 12;
    localparam int VIDEO_Y_BITWIDTH = 11;

    // 1280x720 @ 60 Hz (74.25 MHz pixel clock)
    localparam int H_ACTIVE_720P = 1280;
    localparam int H_FP_720P     = 110;
    localparam int H_SYNC_720P   = 40;
    localparam int H_BP_720P     = 220;
    localparam int V_ACTIVE_720P = 720;
    localparam int V_FP_720P     = 5;
    localparam int V_SYNC_720P   = 5;
    localparam int V_BP_720P     = 20;

    // Total length of one axis (active + front porch + sync + back porch)
    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_timing_axis.sv
// One raster axis: a wrapping counter plus its active / sync region decode.
// Region order along the axis is active, front porch, sync, back porch.
module video_timing_axis
    import configPackage::*;
#(
    parameter int ACTIVE = 4,
    parameter int FP     = 1,
    parameter int SYNC   = 1,
    parameter int BP     = 1,
    parameter int WIDTH  = 12
) (
    input  logic             I_clk_pixel,
    input  logic             I_reset,
    input  logic             advance,
    output logic [WIDTH-1:0] count,
    output logic             active,
    output logic             sync,
    output logic             wrap
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    // Reject degenerate regions and counters too narrow for the axis length
    if (ACTIVE <= 0 || FP <= 0 || SYNC <= 0 || BP <= 0) begin : g_bad_region
        $error("video_timing_axis: every region length must be non-zero");
    end
    if (longint'(TOTAL) > (longint'(1) << WIDTH)) begin : g_bad_width
        $error("video_timing_axis: axis total does not fit in WIDTH bits");
    end

    localparam logic [WIDTH-1:0] LAST       = WIDTH'(TOTAL - 1);
    localparam logic [WIDTH-1:0] ACT_END    = WIDTH'(ACTIVE);
    localparam logic [WIDTH-1:0] SYNC_BEGIN = WIDTH'(ACTIVE + FP);
    localparam logic [WIDTH-1:0] SYNC_END   = WIDTH'(ACTIVE + FP + SYNC);

    logic at_last;

    // Wrap is an equality test against the last position, never an overflow
    always_comb begin
        at_last = (count == LAST);
        wrap    = advance && at_last;
        active  = (count < ACT_END);
        sync    = (count >= SYNC_BEGIN) && (count < SYNC_END);
    end

    // Position counter: steps only when advance is high, wraps to 0 after LAST
    always_ff @(posedge I_clk_pixel) begin
        if (I_reset) begin
            count <= '0;
        end else if (advance) begin
            count <= at_last ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator for the HDMI output path.
// pixX/pixY describe the current counter state and feed the pixel colour
// generator, whose RGB appears one cycle later. O_de/O_hsync/O_vsync/
// O_frame_start are registered once so they line up with that RGB.
// O_de is the qualifier for the pixel stream: RGB is meaningful only in
// cycles where O_de is 1; there is no backpressure, the raster free-runs.
module video_timing_gen
    import configPackage::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_720P,
    parameter int   H_FP     = H_FP_720P,
    parameter int   H_SYNC   = H_SYNC_720P,
    parameter int   H_BP     = H_BP_720P,
    parameter int   V_ACTIVE = V_ACTIVE_720P,
    parameter int   V_FP     = V_FP_720P,
    parameter int   V_SYNC   = V_SYNC_720P,
    parameter int   V_BP     = V_BP_720P,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic                        I_clk_pixel,
    input  logic                        I_reset,
    output logic [VIDEO_X_BITWIDTH-1:0] pixX,
    output logic [VIDEO_Y_BITWIDTH-1:0] pixY,
    output logic [VIDEO_X_BITWIDTH-1:0] screenWidth,
    output logic [VIDEO_Y_BITWIDTH-1:0] screenHeight,
    output logic                        O_de,
    output logic                        O_hsync,
    output logic                        O_vsync,
    output logic                        O_frame_start
);

    logic [VIDEO_X_BITWIDTH-1:0] h_cnt;
    logic [VIDEO_Y_BITWIDTH-1:0] v_cnt;
    logic                        h_active;
    logic                        h_sync;
    logic                        h_wrap;
    logic                        v_active;
    logic                        v_sync;
    logic                        v_wrap_unused;
    logic                        act;
    logic                        fs;

    // Horizontal counter advances every pixel clock
    video_timing_axis #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .WIDTH  (VIDEO_X_BITWIDTH)
    ) u_h_axis (
        .I_clk_pixel (I_clk_pixel),
        .I_reset     (I_reset),
        .advance     (1'b1),
        .count       (h_cnt),
        .active      (h_active),
        .sync        (h_sync),
        .wrap        (h_wrap)
    );

    // Vertical counter advances once per line, so vsync edges land on line boundaries
    video_timing_axis #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .WIDTH  (VIDEO_Y_BITWIDTH)
    ) u_v_axis (
        .I_clk_pixel (I_clk_pixel),
        .I_reset     (I_reset),
        .advance     (h_wrap),
        .count       (v_cnt),
        .active      (v_active),
        .sync        (v_sync),
        .wrap        (v_wrap_unused)
    );

    // Stage-0 decode; coordinates come straight from the counter registers
    always_comb begin
        act          = h_active && v_active;
        fs           = (h_cnt == '0) && (v_cnt == '0);
        pixX         = act ? h_cnt : '0;
        pixY         = act ? v_cnt : '0;
        screenWidth  = VIDEO_X_BITWIDTH'(H_ACTIVE);
        screenHeight = VIDEO_Y_BITWIDTH'(V_ACTIVE);
    end

    // Stage-1: delay the decode by one cycle to match the colour generator's RGB
    always_ff @(posedge I_clk_pixel) begin
        if (I_reset) begin
            O_de          <= 1'b0;
            O_hsync       <= ~HS_POL;
            O_vsync       <= ~VS_POL;
            O_frame_start <= 1'b0;
        end else begin
            O_de          <= act;
            O_hsync       <= h_sync ? HS_POL : ~HS_POL;
            O_vsync       <= v_sync ? VS_POL : ~VS_POL;
            O_frame_start <= fs;
        end
    end

endmodule
